// File: rtl/dmem_pkg.sv
// Shared definitions for the memory-stage data-memory responder:
// FSM state encoding, latency counter width and an index-width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port DEPTH x 32 data RAM with registered read data.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wd,
    output logic [31:0]      rd
);

    logic [31:0] mem_q [DEPTH];

    // NOTE: the array has no reset; words keep their contents across rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wd;
        end
        rd <= mem_q[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: captures a load/store from EX/MEM,
// stalls the pipeline for LATENCY+1 cycles and presents the result in RESP.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err
);

    localparam int IDX_W = clog2(DEPTH);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               is_rd_q;
    logic               is_wr_q;
    logic               misal_q;
    logic               err_q;

    logic               req;
    logic               access;
    logic               arr_we;
    logic [IDX_W-1:0]   arr_idx;
    logic [31:0]        arr_rd;
    logic               unused_addr_bits;

    assign req    = mem_read | mem_write;
    assign access = (state_q == WAIT) && (cnt_q == '0);

    // A reset on the access edge must abandon the store, so the strobe sees rst_n.
    assign arr_we = access && rst_n && is_wr_q && !misal_q;

    // In IDLE the array already reads the incoming address, so LATENCY=1 has data in time.
    assign arr_idx = (state_q == IDLE) ? addr[IDX_W+1:2] : idx_q;

    assign stall = ((state_q == IDLE) && req) || (state_q == WAIT);
    assign rdata = rdata_q;
    assign err   = err_q;

    assign unused_addr_bits = ^addr[31:IDX_W+2];

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk (clk),
        .we  (arr_we),
        .idx (arr_idx),
        .wd  (wdata_q),
        .rd  (arr_rd)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            is_rd_q <= 1'b0;
            is_wr_q <= 1'b0;
            misal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        idx_q   <= addr[IDX_W+1:2];
                        wdata_q <= wdata;
                        is_rd_q <= mem_read;
                        is_wr_q <= mem_write;
                        misal_q <= |addr[1:0];
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= RESP;
                        err_q   <= misal_q | (is_rd_q & is_wr_q);
                        if (misal_q) begin
                            rdata_q <= '0;
                        end else if (!is_wr_q) begin
                            rdata_q <= arr_rd;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-stage data-memory responder for the pipelined core. It consumes the `mem_read` and `mem_write` controls produced in ID and carried down the pipeline. It services each access with a fixed, parameterised latency and holds the pipeline with `stall` until the access completes. It sits between the EX/MEM register and MEM/WB.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: stall cycles per access; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mem_read`  in  1  load request from EX/MEM.
- `mem_write`  in  1  store request from EX/MEM.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data.
- `rdata`  out  32  load data, registered.
- `stall`  out  1  hold PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB.
- `err`  out  1  one-cycle pulse flagging a faulted access.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE with `req = mem_read | mem_write` = 1:**
  - Capture `addr`, `wdata` and the op.
  - Load the counter with LATENCY-1.
  - Go to WAIT.
- **IDLE with `req` = 0:** stay in IDLE.
- **WAIT:**
  - When the counter is nonzero, decrement it.
  - When the counter is 0, perform the access and go to RESP.
- **RESP:**
  - `rdata` and `err` are valid.
  - Inputs are ignored, because the same instruction is still held in EX/MEM.
  - Next state is IDLE.
- **Access:**
  - Word index is `addr[log2(DEPTH)+1:2]`; higher address bits are ignored, so addresses wrap.
  - A write updates the array at the WAIT→RESP edge.
  - A read loads `rdata` at the same edge.
- **Misaligned (`addr[1:0] != 0`):**
  - No array access.
  - `rdata` is loaded with 0.
  - `err` = 1 in RESP.
- **`mem_read` and `mem_write` both 1:** executed as a write, with `err` = 1 in RESP.
- `rdata` holds its last value outside RESP; it is not cleared on writes.
- `err` is 1 only in RESP, for a faulted access.

## Timing
- `stall` is combinational: (IDLE & req) | WAIT.
- `stall` is low in RESP, so the pipeline advances on the RESP edge.
- A request first seen in cycle 0 holds `stall` high for cycles 0..LATENCY.
  - That is LATENCY+1 stall cycles.
  - RESP is cycle LATENCY+1, and the instruction moves to MEM/WB at the end of that cycle.
- Back-to-back accesses:
  - The next instruction reaches EX/MEM in the cycle after RESP, while the FSM is in IDLE.
  - No request is lost or duplicated.
- Reset (`rst_n` = 0 at an edge):
  - State → IDLE, counter → 0, `rdata` → 0, `err` → 0, so `stall` is 0 once in IDLE.
  - This applies from any state. An in-flight write is abandoned and the array is left unchanged.
  - Array contents are not reset.
- Worst-case throughput: one access per LATENCY+2 cycles.

## Structure
- Shared package `dmem_pkg` holds:
  - the state typedef (IDLE, WAIT, RESP);
  - the counter width constant (4 bits);
  - helper function `clog2` for the index width.
- Sub-module `dmem_array`:
  - synchronous single-port RAM, DEPTH×32;
  - ports `we`, `idx`, `wd`, `rd`;
  - no reset;
  - read data registered.
- Top level holds the FSM, counter, capture registers and error logic.

## Test plan
- Reset, then store 0xDEADBEEF to addr 0x10 with LATENCY=2:
  - `stall` is high 3 cycles, then RESP.
  - A later load of 0x10 returns 0xDEADBEEF in its RESP cycle.
- Back-to-back load/load from 0x10 and 0x14:
  - Two distinct RESP cycles, 4 cycles apart.
  - Correct data in each; `stall` is low exactly in each RESP cycle.
- Load from 0x13:
  - `err` = 1 for one cycle in RESP, `rdata` = 0.
  - The array is unchanged, checked by a load of 0x10.
- `mem_read` = `mem_write` = 1 with addr 0x20, `wdata` 0x12345678:
  - `err` pulses.
  - A subsequent load of 0x20 returns 0x12345678.
- Wrap: with DEPTH=256, a store to 0x400 followed by a load of 0x000 returns the stored value.
- Assert `rst_n` = 0 in WAIT during a store to 0x30:
  - Next cycle `stall` = 0, `rdata` = 0 and the state is IDLE.
  - A load of 0x30 returns its pre-store value.
  - Repeat with LATENCY=1, confirming 2 stall cycles.
